// File: rtl/master_xfer_ctrl.sv
// ============================================================================
// Module   : master_xfer_ctrl
// Brief    : Valid/ready bus master: sends a table-selected command word and
//            captures the slave response, with per-phase timeout reporting.
// Revision : 1.0
// ============================================================================
`default_nettype none

module master_xfer_ctrl #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 2,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] address,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              s_ready,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] rdata
);

  localparam int               c_DEPTH   = 2 ** ADDR_W;
  localparam int               c_CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_RESP = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                w_timeout;
  logic [c_CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0]   r_table [c_DEPTH];
  logic [DATA_W-1:0]   r_m_data;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_err;

  // Power-on table contents: alternating 10 / 1100 patterns, all ones elsewhere.
  function automatic logic [DATA_W-1:0] init_entry(input int idx);
    logic [DATA_W-1:0] v;
    v = '1;
    if (idx == 0) begin
      v = '0;
      for (int b = 0; b < 2 * (DATA_W / 2); b++) v[b] = (b % 2 == 1);
      if (DATA_W == 8) v = DATA_W'(8'hA5);
    end else if (idx == 1) begin
      v = '0;
      for (int b = 0; b < 4 * (DATA_W / 4); b++) v[b] = (b % 4 >= 2);
      if (DATA_W == 8) v = DATA_W'(8'hC3);
    end
    return v;
  endfunction

  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_next = SEND;
      end
      SEND: begin
        if (s_ready) begin
          w_next = WAIT_RESP;
        end else if (r_cnt == c_CNT_LAST) begin
          w_next    = DONE;
          w_timeout = 1'b1;
        end
      end
      WAIT_RESP: begin
        if (s_valid) begin
          w_next = DONE;
        end else if (r_cnt == c_CNT_LAST) begin
          w_next    = DONE;
          w_timeout = 1'b1;
        end
      end
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_m_data <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
      for (int i = 0; i < c_DEPTH; i++) r_table[i] <= init_entry(i);
    end else begin
      // The table read below sees the pre-write value on a same-edge collision.
      if (cfg_we) r_table[cfg_addr] <= cfg_data;

      case (r_state)
        IDLE: begin
          if (start) begin
            r_m_data <= r_table[address];
            r_err    <= 1'b0;
            r_cnt    <= '0;
          end
        end
        SEND: begin
          if (s_ready) r_cnt <= '0;
          else         r_cnt <= r_cnt + 1'b1;
        end
        WAIT_RESP: begin
          if (s_valid) r_rdata <= s_data;
          else         r_cnt   <= r_cnt + 1'b1;
        end
        default: ;
      endcase

      if (w_timeout) r_err <= 1'b1;
    end
  end

  // Outputs decode only registered state, never a live input.
  assign m_valid = (r_state == SEND);
  assign m_ready = (r_state == WAIT_RESP);
  assign busy    = (r_state != IDLE);
  assign done    = (r_state == DONE);
  assign m_data  = r_m_data;
  assign rdata   = r_rdata;
  assign err     = r_err;

endmodule

`default_nettype wire

// File: tb/tb_master_xfer_ctrl.sv
// ============================================================================
// Module   : tb_master_xfer_ctrl
// Brief    : Scoreboard bench for master_xfer_ctrl with a responsive slave.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_master_xfer_ctrl;

  localparam int TO = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [1:0] address = '0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_addr = '0;
  logic [7:0] cfg_data = '0;
  logic       m_valid;
  logic [7:0] m_data;
  logic       s_ready = 1'b0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = '0;
  logic       m_ready;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] rdata;

  master_xfer_ctrl #(.DATA_W(8), .ADDR_W(2), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .address(address),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .m_valid(m_valid), .m_data(m_data), .s_ready(s_ready),
    .s_valid(s_valid), .s_data(s_data), .m_ready(m_ready),
    .busy(busy), .done(done), .err(err), .rdata(rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] cmd;
    logic       err;
    logic [7:0] rdata;
    logic [7:0] lat;
    logic [7:0] nsend;
    logic [7:0] nwait;
  } exp_t;

  exp_t       exp_q[$];
  int         n_cmp = 0;
  int         n_fail = 0;
  logic [7:0] mtab [4];
  logic [7:0] last_r;

  // Slave behaviour knobs: ready/valid are withheld for dr/dv phase cycles.
  int         dr = 0;
  int         dv = 0;
  logic [7:0] sdat = '0;
  int         snd_cnt = 0;
  int         rsp_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    mtab[0] = 8'hA5; mtab[1] = 8'hC3; mtab[2] = 8'hFF; mtab[3] = 8'hFF;
    last_r  = 8'h00;
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      s_ready = (snd_cnt >= dr);
      snd_cnt++;
    end else begin
      s_ready = 1'b0;
      snd_cnt = 0;
    end
    if (m_ready) begin
      s_valid = (rsp_cnt >= dv);
      rsp_cnt++;
    end else begin
      s_valid = 1'b0;
      rsp_cnt = 0;
    end
    s_data = s_valid ? sdat : 8'($urandom);
  end

  // Monitor: measures each transfer and compares at its done pulse.
  int   bcnt = 0, scnt = 0, wcnt = 0, bad = 0;
  logic chk_idle = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      bcnt = 0; scnt = 0; wcnt = 0; bad = 0; chk_idle = 1'b0;
    end else begin
      if (chk_idle) begin
        chk("busy_after_done", 32'(busy), 32'd0);
        chk_idle = 1'b0;
      end
      if (m_valid && m_ready) chk("valid_ready_overlap", 32'd1, 32'd0);
      if (busy) bcnt++;
      if (m_valid) begin
        scnt++;
        if (exp_q.size() > 0 && m_data !== exp_q[0].cmd) bad++;
      end
      if (m_ready) wcnt++;
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("busy_in_done", 32'(busy), 32'd1);
          chk("m_data", 32'(m_data), 32'(e.cmd));
          chk("m_data_stable", 32'(bad), 32'd0);
          chk("err", 32'(err), 32'(e.err));
          chk("rdata", 32'(rdata), 32'(e.rdata));
          chk("latency", 32'(bcnt), 32'(e.lat));
          chk("send_cycles", 32'(scnt), 32'(e.nsend));
          chk("wait_cycles", 32'(wcnt), 32'(e.nwait));
        end
        bcnt = 0; scnt = 0; wcnt = 0; bad = 0; chk_idle = 1'b1;
      end
    end
  end

  task automatic xfer(input int a, input int r, input int v, input logic [7:0] sd,
                      input bit coll, input logic [7:0] cdat, input bit midw, input bit ign);
    exp_t e;
    bit   got, pulsed;
    e.cmd = mtab[a];
    if (r >= TO) begin
      e.err = 1'b1; e.rdata = last_r; e.nsend = 8'(TO); e.nwait = 8'd0; e.lat = 8'(TO + 1);
    end else if (v >= TO) begin
      e.err = 1'b1; e.rdata = last_r; e.nsend = 8'(r + 1); e.nwait = 8'(TO);
      e.lat = 8'(r + 1 + TO + 1);
    end else begin
      e.err = 1'b0; e.rdata = sd; last_r = sd; e.nsend = 8'(r + 1); e.nwait = 8'(v + 1);
      e.lat = 8'(r + v + 3);
    end
    exp_q.push_back(e);

    @(negedge clk);
    dr = r; dv = v; sdat = sd;
    start = 1'b1; address = 2'(a);
    if (coll) begin
      cfg_we = 1'b1; cfg_addr = 2'(a); cfg_data = cdat; mtab[a] = cdat;
    end
    got = 1'b0; pulsed = 1'b0;
    for (int k = 1; k <= 200 && !got; k++) begin
      @(negedge clk);
      start  = 1'b0;
      cfg_we = 1'b0;
      if (k == 1 && midw) begin
        cfg_we = 1'b1; cfg_addr = 2'($urandom); cfg_data = 8'($urandom);
        mtab[cfg_addr] = cfg_data;
      end
      if (done) got = 1'b1;
      else if (ign && !pulsed && m_ready) begin
        start = 1'b1; address = 2'($urandom); pulsed = 1'b1;
      end
    end
    start  = 1'b0;
    cfg_we = 1'b0;
    if (!got) chk("done_wait_expired", 32'd0, 32'd1);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({m_valid, m_ready, busy, done, err, m_data, rdata}), 32'd0);
    @(posedge clk);
    #2 rst = 1'b1;

    xfer(0, 0, 0, 8'h77, 1'b0, 8'h00, 1'b0, 1'b0);   // minimum latency, A5
    xfer(1, 0, 0, 8'h5A, 1'b0, 8'h00, 1'b0, 1'b0);   // C3, rdata 5A
    xfer(3, 0, 0, 8'h12, 1'b0, 8'h00, 1'b0, 1'b0);   // FF
    xfer(2, 1, 0, 8'h34, 1'b1, 8'h3C, 1'b0, 1'b0);   // collision: old FF
    xfer(2, 0, 1, 8'h56, 1'b0, 8'h00, 1'b0, 1'b0);   // now 3C
    xfer(1, 5, 4, 8'h9B, 1'b0, 8'h00, 1'b0, 1'b0);   // back-pressure
    xfer(0, 20, 0, 8'hEE, 1'b0, 8'h00, 1'b0, 1'b0);  // SEND timeout
    xfer(0, 14, 0, 8'h61, 1'b0, 8'h00, 1'b0, 1'b0);  // handshake on last cycle
    xfer(3, 2, 15, 8'hDD, 1'b0, 8'h00, 1'b0, 1'b0);  // WAIT_RESP timeout
    xfer(3, 0, 14, 8'h42, 1'b0, 8'h00, 1'b0, 1'b0);  // response on last cycle
    xfer(1, 1, 3, 8'h24, 1'b0, 8'h00, 1'b0, 1'b1);   // ignored start

    // Abort mid-SEND after modifying the table: reset must restore it.
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = 8'h11; mtab[0] = 8'h11;
    @(negedge clk);
    cfg_we = 1'b0; dr = 30; start = 1'b1; address = 2'd1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1 chk("abort_outputs", 32'({m_valid, m_ready, busy, done, err, m_data, rdata}), 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    xfer(0, 0, 0, 8'h3E, 1'b0, 8'h00, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      int a, r, v;
      a = int'($urandom_range(0, 3));
      r = ($urandom_range(0, 3) == 0) ? int'($urandom_range(12, 17)) : int'($urandom_range(0, 4));
      v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(12, 17)) : int'($urandom_range(0, 4));
      xfer(a, r, v, 8'($urandom), 1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/master_xfer_ctrl.md
# master_xfer_ctrl

Parametrised bus master that sends one command word to a slave over a valid/ready handshake and captures the slave's response word. Command words come from a programmable pattern table indexed by an address input. Each handshake phase has a timeout with error reporting. The block sits between local control logic and a slave port, in the same position as the fixed-pattern master I/O.

## Interface
- DATA_W, 8: width of command and response words.
- ADDR_W, 2: table index width; table holds 2**ADDR_W entries.
- TIMEOUT, 15: maximum cycles to wait in each handshake phase; must be ≥ 1.

- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  request a transfer; sampled only in IDLE.
- address  in  ADDR_W  table index, latched with start.
- cfg_we  in  1  table write enable.
- cfg_addr  in  ADDR_W  table write index.
- cfg_data  in  DATA_W  table write data.
- m_valid  out  1  command word valid toward slave.
- m_data  out  DATA_W  command word.
- s_ready  in  1  slave accepts command.
- s_valid  in  1  slave response valid.
- s_data  in  DATA_W  slave response word.
- m_ready  out  1  master accepts response.
- busy  out  1  high in any state but IDLE.
- done  out  1  one-cycle pulse at end of transfer (success or timeout).
- err  out  1  timeout flag; valid while done=1, held until next start.
- rdata  out  DATA_W  last captured response word.

## Operation
- FSM states: IDLE, SEND, WAIT_RESP, DONE.
- IDLE: if start=1 at a clock edge, latch m_data ← table[address], clear err, clear the timeout counter, go to SEND.
- SEND: m_valid=1, m_data stable. On an edge with s_ready=1, the command transfers; clear the counter and go to WAIT_RESP.
- WAIT_RESP: m_ready=1. On an edge with s_valid=1, rdata ← s_data and go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Timeout: the counter is $clog2(TIMEOUT+1) bits wide and increments on every SEND or WAIT_RESP cycle without a handshake. When it equals TIMEOUT-1 and there is still no handshake, the next state is DONE with err ← 1 and rdata unchanged.
- A handshake on the final allowed cycle beats the timeout; that case is a success with err=0.
- Pattern table reset contents:
  - entry 0 = repeating 1010… (8'hA5 style pattern for DATA_W=8: 8'hA5).
  - entry 1 = 8'hC3 when DATA_W=8; otherwise repeating 1100…
  - all other entries = all ones.
- For DATA_W≠8, entry 0 = {DATA_W/2{2'b10}} and entry 1 = {DATA_W/4{4'b1100}}, with the MSBs truncated or zero-padded to width.
- cfg_we writes table[cfg_addr] ← cfg_data at the edge in any state.
- An in-flight transfer is unaffected by table writes, because m_data is latched.
- A start and a cfg_we to the same index on the same edge: the transfer uses the old entry value.
- start outside IDLE is ignored; it is not queued.

## Timing
- Reset (rst=0, asynchronous) forces:
  - state IDLE, counter 0.
  - m_valid=0, m_ready=0, busy=0, done=0, err=0.
  - m_data=0, rdata=0.
  - table restored to its reset contents.
- Release of rst is synchronous to clk. The first start is accepted on the first edge after release.
- Reset asserted mid-transfer aborts immediately. No done pulse is produced.
- Minimum latency, with s_ready and s_valid held high:
  - start at edge 0.
  - m_valid high in cycle 1.
  - m_ready high in cycle 2.
  - done high in cycle 3.
  - busy low again in cycle 4.
- A timeout in SEND produces done exactly TIMEOUT+1 cycles after the start edge (counting cycles after the edge, with busy asserted).
- m_valid and m_ready are never high together.
- done and busy are both high in the DONE cycle.
- All outputs are registered; none depends combinationally on an input.

## Test plan
- Reset defaults: assert rst=0 mid-SEND → all outputs 0 immediately. After release, start with address=0 and immediate slave → m_data=8'hA5, done in cycle 3, err=0.
- Fixed patterns: start at address 1 with s_data=8'h5A → m_data=8'hC3, rdata=8'h5A. Start at address 3 → m_data=8'hFF.
- Table write collision: cfg_we with cfg_addr=2, cfg_data=8'h3C on the same edge as start at address 2 → m_data=8'hFF. A second start at address 2 → m_data=8'h3C.
- Back-pressure: hold s_ready=0 for 5 cycles, then s_valid=0 for 4 cycles → m_valid held 6 cycles with m_data stable, m_ready held 5 cycles, err=0.
- Timeout: TIMEOUT=15, s_ready stuck 0 → done after 15 SEND cycles with err=1 and rdata unchanged. Repeat with s_ready=1 on the 15th cycle → success, err=0.
- Ignored start: pulse start during WAIT_RESP → no second transfer. busy drops one cycle after the single done pulse.
